// File: rtl/pomdp_pkg.sv
// Shared types and sizes for the PBVI backup pipeline.
// The sizes here set the widths of the step3_select ports and registers.
package pomdp_pkg;

  localparam int NUM_POINTS  = 16;
  localparam int NUM_ACTIONS = 3;
  localparam int NUM_STATES  = 2;
  localparam int WORD_W      = 16;
  localparam int PT_W        = $clog2(NUM_POINTS);

  typedef logic [WORD_W-1:0]           word_t;
  typedef logic [2*WORD_W:0]           dot_t;
  typedef logic [1:0]                  action_t;
  typedef word_t [0:NUM_STATES-1]      alpha_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_DONE    = 2'd3
  } step3_state_t;

endpackage

// File: rtl/dot2_q16.sv
// Two-term unsigned Q0.16 dot product. The 33-bit result keeps the carry out
// of the sum, so values near 2.0 still compare correctly.
module dot2_q16
  import pomdp_pkg::*;
(
  input  word_t a0,
  input  word_t a1,
  input  word_t b0,
  input  word_t b1,
  output dot_t  dot
);

  logic [2*WORD_W-1:0] prod0;
  logic [2*WORD_W-1:0] prod1;

  assign prod0 = (2*WORD_W)'(a0) * (2*WORD_W)'(b0);
  assign prod1 = (2*WORD_W)'(a1) * (2*WORD_W)'(b1);
  assign dot   = (2*WORD_W+1)'(prod0) + (2*WORD_W+1)'(prod1);

endmodule

// File: rtl/step3_select.sv
// Per-point action selection: picks the candidate alpha vector with the best
// belief-weighted value for each point, one point per cycle.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | waiting for a rising edge on en
// ST_CAPTURE | latching candidate vectors and beliefs, clearing point index
// ST_COMPUTE | evaluating and writing one point per cycle
// ST_DONE    | single-cycle completion pulse
module step3_select
  import pomdp_pkg::*;
(
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       en,
  input  alpha_t [0:NUM_ACTIONS-1][0:NUM_POINTS-1]   gamma_action_belief,
  input  alpha_t [0:NUM_POINTS-1]                    point_belief,
  output alpha_t [0:NUM_POINTS-1]                    alpha_out,
  output action_t [0:NUM_POINTS-1]                   action_out,
  output logic                                       busy,
  output logic                                       done
);

  localparam logic [PT_W-1:0] P_LAST = PT_W'(NUM_POINTS - 1);

  step3_state_t                              state;
  logic                                      en_d;
  logic                                      start;
  logic [PT_W-1:0]                           p;
  alpha_t [0:NUM_ACTIONS-1][0:NUM_POINTS-1]  g_q;
  alpha_t [0:NUM_POINTS-1]                   b_q;
  alpha_t                                    b_cur;
  dot_t                                      v [NUM_ACTIONS];
  action_t                                   best;
  dot_t                                      best_v;
  alpha_t                                    best_g;

  assign start = en & ~en_d;
  assign busy  = (state == ST_CAPTURE) || (state == ST_COMPUTE);
  assign done  = (state == ST_DONE);
  assign b_cur = b_q[p];

  for (genvar a = 0; a < NUM_ACTIONS; a++) begin : g_dot
    dot2_q16 u_dot (
      .a0  (g_q[a][p][0]),
      .a1  (g_q[a][p][1]),
      .b0  (b_cur[0]),
      .b1  (b_cur[1]),
      .dot (v[a])
    );
  end

  // Strict greater-than keeps the lowest action index on ties.
  always_comb begin
    best   = '0;
    best_v = v[0];
    best_g = g_q[0][p];
    for (int a = 1; a < NUM_ACTIONS; a++) begin
      if (v[a] > best_v) begin
        best   = action_t'(a);
        best_v = v[a];
        best_g = g_q[a][p];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      en_d       <= 1'b0;
      p          <= '0;
      g_q        <= '0;
      b_q        <= '0;
      alpha_out  <= '0;
      action_out <= '0;
    end else begin
      en_d <= en;
      // A new start from any state abandons the current pass.
      if (start) begin
        state <= ST_CAPTURE;
      end else begin
        case (state)
          ST_IDLE: begin
            state <= ST_IDLE;
          end
          ST_CAPTURE: begin
            g_q   <= gamma_action_belief;
            b_q   <= point_belief;
            p     <= '0;
            state <= ST_COMPUTE;
          end
          ST_COMPUTE: begin
            alpha_out[p]  <= best_g;
            action_out[p] <= best;
            if (p == P_LAST) begin
              state <= ST_DONE;
            end else begin
              p <= p + PT_W'(1);
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
